// File: rtl/vx_tex_rsp_arb_pkg.sv
// Shared texture-response types and sizing helpers for the texture response path.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef NW_BITS
`define NW_BITS 4
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef TEX_NUM_LANES
`define TEX_NUM_LANES `NUM_THREADS
`endif
`ifndef TEX_DATA_WIDTH
`define TEX_DATA_WIDTH 32
`endif

package vx_tex_rsp_arb_pkg;

  localparam int UUID_W     = `UUID_BITS;
  localparam int NW_W       = `NW_BITS;
  localparam int NR_W       = `NR_BITS;
  localparam int PC_W       = 32;
  localparam int LANES_DEF  = `TEX_NUM_LANES;
  localparam int DATA_W_DEF = `TEX_DATA_WIDTH;

  typedef struct packed {
    logic [UUID_W-1:0]                      uuid;
    logic [NW_W-1:0]                        wid;
    logic [LANES_DEF-1:0]                   tmask;
    logic [PC_W-1:0]                        PC;
    logic [NR_W-1:0]                        rd;
    logic                                   wb;
    logic [LANES_DEF-1:0][DATA_W_DEF-1:0]   data;
  } tex_rsp_t;

  // A single channel still needs a one-bit select field.
  function automatic int req_sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer and holds a stalled grant until it completes a handshake.
module vx_rr_arbiter
  import vx_tex_rsp_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int SEL_BITS = req_sel_bits(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] req,
  input  logic                advance,
  output logic                grant_valid,
  output logic [SEL_BITS-1:0] grant_idx,
  output logic [NUM_REQS-1:0] grant_onehot
);

  localparam logic [SEL_BITS:0] NUM_W = (SEL_BITS+1)'(NUM_REQS);

  logic [SEL_BITS-1:0] ptr_r;
  logic [SEL_BITS-1:0] lock_idx_r;
  logic                lock_r;
  logic [SEL_BITS-1:0] pick_idx_s;
  logic                pick_valid_s;
  logic [SEL_BITS-1:0] cand_s;
  logic                hit_s;
  logic                lock_hit_s;
  logic [SEL_BITS-1:0] next_ptr_s;

  function automatic logic [SEL_BITS-1:0] wrap_sel(input logic [SEL_BITS:0] v);
    return (v >= NUM_W) ? SEL_BITS'(v - NUM_W) : v[SEL_BITS-1:0];
  endfunction

  function automatic logic [NUM_REQS-1:0] to_onehot(input logic [SEL_BITS-1:0] i);
    logic [NUM_REQS-1:0] oh;
    for (int j = 0; j < NUM_REQS; j++) oh[j] = (i == SEL_BITS'(j));
    return oh;
  endfunction

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick_idx_s   = ptr_r;
    pick_valid_s = 1'b0;
    cand_s       = {SEL_BITS{1'b0}};
    hit_s        = 1'b0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      cand_s       = wrap_sel({1'b0, ptr_r} + (SEL_BITS+1)'(k));
      hit_s        = |(req & to_onehot(cand_s));
      pick_idx_s   = hit_s ? cand_s : pick_idx_s;
      pick_valid_s = pick_valid_s | hit_s;
    end
  end

  // A stalled winner keeps the grant even if a nearer channel turns valid.
  assign lock_hit_s   = lock_r & (|(req & to_onehot(lock_idx_r)));
  assign grant_idx    = lock_hit_s ? lock_idx_r : pick_idx_s;
  assign grant_valid  = lock_hit_s | pick_valid_s;
  assign grant_onehot = grant_valid ? to_onehot(grant_idx) : {NUM_REQS{1'b0}};
  assign next_ptr_s   = wrap_sel({1'b0, grant_idx} + {{SEL_BITS{1'b0}}, 1'b1});

  // Priority pointer and grant lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r      <= {SEL_BITS{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {SEL_BITS{1'b0}};
    end else if (advance) begin
      ptr_r      <= next_ptr_s;
      lock_r     <= 1'b0;
    end else begin
      lock_r     <= grant_valid;
      lock_idx_r <= grant_idx;
    end
  end

endmodule

// File: rtl/vx_tex_rsp_arb.sv
// Texture response arbiter: merges NUM_REQS response channels into one stream,
// discarding empty-mask responses and optionally registering the output.
module vx_tex_rsp_arb
  import vx_tex_rsp_arb_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int NUM_LANES    = LANES_DEF,
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFERED     = 1,
  parameter int REQ_SEL_BITS = req_sel_bits(NUM_REQS)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [NUM_REQS-1:0]                            in_valid,
  input  logic [NUM_REQS-1:0][UUID_W-1:0]                in_uuid,
  input  logic [NUM_REQS-1:0][NW_W-1:0]                  in_wid,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]             in_tmask,
  input  logic [NUM_REQS-1:0][PC_W-1:0]                  in_PC,
  input  logic [NUM_REQS-1:0][NR_W-1:0]                  in_rd,
  input  logic [NUM_REQS-1:0]                            in_wb,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DATA_WIDTH-1:0] in_data,
  output logic [NUM_REQS-1:0]                            in_ready,
  output logic                                           out_valid,
  output logic [UUID_W-1:0]                              out_uuid,
  output logic [NW_W-1:0]                                out_wid,
  output logic [NUM_LANES-1:0]                           out_tmask,
  output logic [PC_W-1:0]                                out_PC,
  output logic [NR_W-1:0]                                out_rd,
  output logic                                           out_wb,
  output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]           out_data,
  output logic [REQ_SEL_BITS-1:0]                        out_sel,
  input  logic                                           out_ready,
  output logic [31:0]                                    perf_drops
);

  localparam int PW = UUID_W + NW_W + NUM_LANES + PC_W + NR_W + 1
                    + NUM_LANES * DATA_WIDTH + REQ_SEL_BITS;

  logic                    grant_valid_s;
  logic [REQ_SEL_BITS-1:0] grant_idx_s;
  logic [NUM_REQS-1:0]     grant_oh_s;
  logic                    empty_s;
  logic                    discard_s;
  logic                    accept_s;
  logic                    handshake_s;
  logic                    push_s;
  logic                    buf_full_s;
  logic [PW-1:0]           pay_s;
  logic [PW-1:0]           out_word_s;
  logic [31:0]             drops_r;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS),
    .SEL_BITS (REQ_SEL_BITS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .req          (in_valid),
    .advance      (handshake_s),
    .grant_valid  (grant_valid_s),
    .grant_idx    (grant_idx_s),
    .grant_onehot (grant_oh_s)
  );

  assign pay_s = {in_uuid[grant_idx_s], in_wid[grant_idx_s], in_tmask[grant_idx_s],
                  in_PC[grant_idx_s], in_rd[grant_idx_s], in_wb[grant_idx_s],
                  in_data[grant_idx_s], grant_idx_s};

  // Empty-mask responses are swallowed whatever the output side is doing.
  assign empty_s     = (in_tmask[grant_idx_s] == {NUM_LANES{1'b0}});
  assign discard_s   = grant_valid_s & empty_s & ~reset;
  assign accept_s    = ~reset & (empty_s | ((BUFFERED != 0) ? ~buf_full_s : out_ready));
  assign handshake_s = grant_valid_s & accept_s;
  assign push_s      = handshake_s & ~empty_s;
  assign in_ready    = accept_s ? grant_oh_s : {NUM_REQS{1'b0}};

  if (BUFFERED != 0) begin : g_buf
    logic [1:0]    cnt_r;
    logic [PW-1:0] ent0_r;
    logic [PW-1:0] ent1_r;
    logic          pop_s;

    assign pop_s = (cnt_r != 2'd0) & out_ready;

    // Two-entry skid buffer; ent0_r always holds the presented response.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_r <= 2'd0;
      end else begin
        case (cnt_r)
          2'd0: begin
            if (push_s) begin
              ent0_r <= pay_s;
              cnt_r  <= 2'd1;
            end
          end
          2'd1: begin
            if (push_s && pop_s) begin
              ent0_r <= pay_s;
            end else if (push_s) begin
              ent1_r <= pay_s;
              cnt_r  <= 2'd2;
            end else if (pop_s) begin
              cnt_r  <= 2'd0;
            end
          end
          2'd2: begin
            if (pop_s) begin
              ent0_r <= ent1_r;
              cnt_r  <= 2'd1;
            end
          end
          default: cnt_r <= 2'd0;
        endcase
      end
    end

    assign buf_full_s = (cnt_r == 2'd2);
    assign out_valid  = (cnt_r != 2'd0);
    assign out_word_s = ent0_r;
  end else begin : g_comb
    assign buf_full_s = 1'b0;
    assign out_valid  = grant_valid_s & ~empty_s & ~reset;
    assign out_word_s = pay_s;
  end

  assign {out_uuid, out_wid, out_tmask, out_PC, out_rd, out_wb, out_data, out_sel} = out_word_s;

  // Saturating count of discarded responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      drops_r <= 32'd0;
    end else if (discard_s && (drops_r != 32'hFFFF_FFFF)) begin
      drops_r <= drops_r + 32'd1;
    end
  end

  assign perf_drops = drops_r;

endmodule

// File: tb/tb_vx_tex_rsp_arb.sv
// Directed bench: one buffered and one combinational arbiter share input channels.
module tb_vx_tex_rsp_arb;
  import vx_tex_rsp_arb_pkg::*;

  localparam int N  = 4;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int SB = 2;
  localparam int PW = UUID_W + NW_W + L + PC_W + NR_W + 1 + L * DW + SB;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]                 in_valid;
  logic [N-1:0][UUID_W-1:0]     in_uuid;
  logic [N-1:0][NW_W-1:0]       in_wid;
  logic [N-1:0][L-1:0]          in_tmask;
  logic [N-1:0][PC_W-1:0]       in_PC;
  logic [N-1:0][NR_W-1:0]       in_rd;
  logic [N-1:0]                 in_wb;
  logic [N-1:0][L-1:0][DW-1:0]  in_data;

  logic [N-1:0] in_ready_b, in_ready_c;
  logic out_valid_b, out_valid_c, out_wb_b, out_wb_c, out_ready_b, out_ready_c;
  logic [UUID_W-1:0] out_uuid_b, out_uuid_c;
  logic [NW_W-1:0]   out_wid_b, out_wid_c;
  logic [L-1:0]      out_tmask_b, out_tmask_c;
  logic [PC_W-1:0]   out_PC_b, out_PC_c;
  logic [NR_W-1:0]   out_rd_b, out_rd_c;
  logic [L-1:0][DW-1:0] out_data_b, out_data_c;
  logic [SB-1:0]     out_sel_b, out_sel_c;
  logic [31:0]       perf_drops_b, perf_drops_c;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vx_tex_rsp_arb #(.NUM_REQS(N), .NUM_LANES(L), .DATA_WIDTH(DW), .BUFFERED(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb), .in_data(in_data),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_uuid(out_uuid_b), .out_wid(out_wid_b),
    .out_tmask(out_tmask_b), .out_PC(out_PC_b), .out_rd(out_rd_b), .out_wb(out_wb_b),
    .out_data(out_data_b), .out_sel(out_sel_b), .out_ready(out_ready_b), .perf_drops(perf_drops_b)
  );

  vx_tex_rsp_arb #(.NUM_REQS(N), .NUM_LANES(L), .DATA_WIDTH(DW), .BUFFERED(0)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb), .in_data(in_data),
    .in_ready(in_ready_c), .out_valid(out_valid_c), .out_uuid(out_uuid_c), .out_wid(out_wid_c),
    .out_tmask(out_tmask_c), .out_PC(out_PC_c), .out_rd(out_rd_c), .out_wb(out_wb_c),
    .out_data(out_data_c), .out_sel(out_sel_c), .out_ready(out_ready_c), .perf_drops(perf_drops_c)
  );

  function automatic logic [PW-1:0] exp_word(input logic [15:0] tag, input logic [3:0] tm,
                                             input logic [1:0] sel);
    return {UUID_W'(tag), NW_W'(tag), tm, 32'h0000_1000 + {14'd0, tag, 2'b00}, NR_W'(tag),
            tag[0], tag, 16'd3, tag, 16'd2, tag, 16'd1, tag, 16'd0, sel};
  endfunction

  task automatic set_ch(input logic [1:0] ch, input logic [15:0] tag, input logic [3:0] tm);
    in_uuid[ch]  = UUID_W'(tag);
    in_wid[ch]   = NW_W'(tag);
    in_tmask[ch] = tm;
    in_PC[ch]    = 32'h0000_1000 + 32'(tag) * 32'd4;
    in_rd[ch]    = NR_W'(tag);
    in_wb[ch]    = tag[0];
    in_data[ch]  = {{tag, 16'd3}, {tag, 16'd2}, {tag, 16'd1}, {tag, 16'd0}};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < N; c++) set_ch(2'(c), 16'h0010 + 16'(c), 4'hF);
    in_valid = 4'hF;
    #1;
    total_cnt++;
    if (in_ready_b !== 4'b0000) $display("FAIL reset_in_ready_b got=%b want=0000", in_ready_b);
    else pass_cnt++;
    total_cnt++;
    if (in_ready_c !== 4'b0000) $display("FAIL reset_in_ready_c got=%b want=0000", in_ready_c);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid_b, out_valid_c} !== 2'b00)
      $display("FAIL reset_out_valid got=%b want=00", {out_valid_b, out_valid_c});
    else pass_cnt++;
    total_cnt++;
    if ({perf_drops_b, dut_b.u_arb.ptr_r, dut_c.u_arb.ptr_r} !== {32'd0, 2'd0, 2'd0})
      $display("FAIL reset_state got drops=%h ptr_b=%0d ptr_c=%0d want 0/0/0",
               perf_drops_b, dut_b.u_arb.ptr_r, dut_c.u_arb.ptr_r);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] sel;
    logic [1:0] prev;
    out_ready_b = 1'b1;
    out_ready_c = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel  = 2'(k % 4);
      prev = 2'((k + 3) % 4);
      #1;
      total_cnt++;
      if ({out_valid_c, out_sel_c, in_ready_c} !== {1'b1, sel, 4'(4'b0001 << sel)})
        $display("FAIL rr_comb k=%0d got v=%b sel=%0d rdy=%b want v=1 sel=%0d", k,
                 out_valid_c, out_sel_c, in_ready_c, sel);
      else pass_cnt++;
      total_cnt++;
      if (out_uuid_c !== UUID_W'(16'h0010 + 16'(sel)))
        $display("FAIL rr_uuid k=%0d got=%h want=%h", k, out_uuid_c, 16'h0010 + 16'(sel));
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if ({out_valid_b, out_sel_b} !== {1'b1, prev})
          $display("FAIL rr_buf k=%0d got v=%b sel=%0d want v=1 sel=%0d", k,
                   out_valid_b, out_sel_b, prev);
        else pass_cnt++;
      end
      step();
    end
  endtask

  task automatic test_single();
    in_valid = 4'b0000;
    step();
    set_ch(2'd2, 16'h0015, 4'b1010);
    in_valid = 4'b0100;
    #1;
    total_cnt++;
    if ({out_valid_c, out_uuid_c, out_wid_c, out_tmask_c, out_PC_c, out_rd_c, out_wb_c,
         out_data_c, out_sel_c} !== {1'b1, exp_word(16'h0015, 4'b1010, 2'd2)})
      $display("FAIL single_comb got v=%b uuid=%h tm=%b sel=%0d PC=%h want v=1 uuid=15 tm=1010 sel=2 PC=1054",
               out_valid_c, out_uuid_c, out_tmask_c, out_sel_c, out_PC_c);
    else pass_cnt++;
    total_cnt++;
    if (out_valid_b !== 1'b0) $display("FAIL single_buf_early got=%b want=0", out_valid_b);
    else pass_cnt++;
    step();
    in_valid = 4'b0000;
    total_cnt++;
    if ({out_valid_b, out_uuid_b, out_wid_b, out_tmask_b, out_PC_b, out_rd_b, out_wb_b,
         out_data_b, out_sel_b} !== {1'b1, exp_word(16'h0015, 4'b1010, 2'd2)})
      $display("FAIL single_buf got v=%b uuid=%h tm=%b sel=%0d PC=%h want v=1 uuid=15 tm=1010 sel=2 PC=1054",
               out_valid_b, out_uuid_b, out_tmask_b, out_sel_b, out_PC_b);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid_b !== 1'b0) $display("FAIL single_buf_drain got=%b want=0", out_valid_b);
    else pass_cnt++;
  endtask

  task automatic test_discard();
    out_ready_b = 1'b0;
    out_ready_c = 1'b0;
    set_ch(2'd1, 16'h0021, 4'b0000);
    in_valid = 4'b0010;
    #1;
    total_cnt++;
    if ({in_ready_b, in_ready_c} !== 8'b0010_0010)
      $display("FAIL discard_ready got b=%b c=%b want 0010/0010", in_ready_b, in_ready_c);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid_b, out_valid_c} !== 2'b00)
      $display("FAIL discard_no_out got=%b want=00", {out_valid_b, out_valid_c});
    else pass_cnt++;
    step();
    in_valid = 4'b0000;
    total_cnt++;
    if ({perf_drops_b, perf_drops_c, out_valid_b} !== {32'd1, 32'd1, 1'b0})
      $display("FAIL discard_count got b=%0d c=%0d v=%b want 1/1/0", perf_drops_b,
               perf_drops_c, out_valid_b);
    else pass_cnt++;
    force dut_b.drops_r = 32'hFFFF_FFFF;
    step();
    release dut_b.drops_r;
    #1;
    total_cnt++;
    if (perf_drops_b !== 32'hFFFF_FFFF) $display("FAIL drops_preset got=%h want=ffffffff", perf_drops_b);
    else pass_cnt++;
    in_valid = 4'b0010;
    step();
    in_valid = 4'b0000;
    total_cnt++;
    if ({perf_drops_b, perf_drops_c} !== {32'hFFFF_FFFF, 32'd2})
      $display("FAIL drops_saturate got b=%h c=%0d want ffffffff/2", perf_drops_b, perf_drops_c);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int  acc;
    logic exp_rdy;
    acc = 0;
    out_ready_b = 1'b0;
    in_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      set_ch(2'd0, 16'h0040 + 16'(acc), 4'hF);
      #1;
      exp_rdy = (c < 2);
      total_cnt++;
      if (in_ready_b[0] !== exp_rdy)
        $display("FAIL bp_ready c=%0d got=%b want=%b", c, in_ready_b[0], exp_rdy);
      else pass_cnt++;
      if (c >= 1) begin
        total_cnt++;
        if ({out_valid_b, out_uuid_b} !== {1'b1, UUID_W'(16'h0040)})
          $display("FAIL bp_hold c=%0d got v=%b uuid=%h want v=1 uuid=40", c, out_valid_b, out_uuid_b);
        else pass_cnt++;
      end
      step();
      if (exp_rdy) acc++;
    end
    in_valid = 4'b0000;
    out_ready_b = 1'b1;
    #1;
    total_cnt++;
    if ({out_valid_b, out_uuid_b} !== {1'b1, UUID_W'(16'h0040)})
      $display("FAIL bp_first got v=%b uuid=%h want v=1 uuid=40", out_valid_b, out_uuid_b);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid_b, out_uuid_b} !== {1'b1, UUID_W'(16'h0041)})
      $display("FAIL bp_second got v=%b uuid=%h want v=1 uuid=41", out_valid_b, out_uuid_b);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid_b !== 1'b0) $display("FAIL bp_empty got=%b want=0", out_valid_b);
    else pass_cnt++;
  endtask

  task automatic test_stall_grant();
    out_ready_c = 1'b1;
    set_ch(2'd0, 16'h0050, 4'hF);
    in_valid = 4'b0001;
    step();
    total_cnt++;
    if (dut_c.u_arb.ptr_r !== 2'd1) $display("FAIL stall_ptr_setup got=%0d want=1", dut_c.u_arb.ptr_r);
    else pass_cnt++;
    out_ready_c = 1'b0;
    set_ch(2'd3, 16'h0053, 4'hF);
    in_valid = 4'b1000;
    #1;
    total_cnt++;
    if ({out_sel_c, in_ready_c} !== {2'd3, 4'b0000})
      $display("FAIL stall_first got sel=%0d rdy=%b want sel=3 rdy=0000", out_sel_c, in_ready_c);
    else pass_cnt++;
    step();
    set_ch(2'd1, 16'h0051, 4'hF);
    set_ch(2'd2, 16'h0052, 4'hF);
    in_valid = 4'b1110;
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++;
      if ({out_valid_c, out_sel_c, dut_c.u_arb.ptr_r} !== {1'b1, 2'd3, 2'd1})
        $display("FAIL stall_hold c=%0d got v=%b sel=%0d ptr=%0d want v=1 sel=3 ptr=1", c,
                 out_valid_c, out_sel_c, dut_c.u_arb.ptr_r);
      else pass_cnt++;
      step();
    end
    out_ready_c = 1'b1;
    #1;
    total_cnt++;
    if (in_ready_c !== 4'b1000) $display("FAIL stall_release got=%b want=1000", in_ready_c);
    else pass_cnt++;
    step();
    in_valid = 4'b0110;
    #1;
    total_cnt++;
    if ({dut_c.u_arb.ptr_r, out_sel_c} !== {2'd0, 2'd1})
      $display("FAIL stall_wrap got ptr=%0d sel=%0d want ptr=0 sel=1", dut_c.u_arb.ptr_r, out_sel_c);
    else pass_cnt++;
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_flush();
    out_ready_b = 1'b0;
    set_ch(2'd0, 16'h0060, 4'hF);
    in_valid = 4'b0001;
    step();
    set_ch(2'd0, 16'h0061, 4'hF);
    step();
    total_cnt++;
    if ({out_valid_b, in_ready_b} !== {1'b1, 4'b0000})
      $display("FAIL flush_full got v=%b rdy=%b want v=1 rdy=0000", out_valid_b, in_ready_b);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 4'b0000;
    #1;
    total_cnt++;
    if ({out_valid_b, dut_b.u_arb.ptr_r, perf_drops_b, perf_drops_c} !== {1'b0, 2'd0, 32'd0, 32'd0})
      $display("FAIL flush_state got v=%b ptr=%0d drops_b=%h drops_c=%0d want 0/0/0/0",
               out_valid_b, dut_b.u_arb.ptr_r, perf_drops_b, perf_drops_c);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid_b !== 1'b0) $display("FAIL flush_empty got=%b want=0", out_valid_b);
    else pass_cnt++;
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 4'b0000;
    in_uuid     = '0;
    in_wid      = '0;
    in_tmask    = '0;
    in_PC       = '0;
    in_rd       = '0;
    in_wb       = '0;
    in_data     = '0;
    out_ready_b = 1'b1;
    out_ready_c = 1'b1;
    test_reset();
    test_round_robin();
    test_single();
    test_discard();
    test_backpressure();
    test_stall_grant();
    test_reset_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
